// File: rtl/minesweeper_pkg.sv
// minesweeper_pkg: shared board geometry, cell typedefs, reveal FSM states and
// neighbour offsets for the 15x15 minesweeper board.
package minesweeper_pkg;

    localparam int unsigned GRID_W    = 15;
    localparam int unsigned GRID_H    = 15;
    localparam int unsigned NUM_CELLS = 225;

    typedef logic [7:0] cell_addr_t;
    typedef logic [3:0] cell_code_t;

    localparam cell_code_t MINE_CODE = 4'd9;

    typedef enum logic [2:0] {
        StIdle,
        StPop,
        StReq,
        StRdata,
        StNeigh,
        StDone
    } reveal_state_t;

    // Neighbour order N, NE, E, SE, S, SW, W, NW; row 0 is the top (N = y-1).
    // 4'hF acts as -1 in 4-bit wrap-around; a wrapped coordinate fails the bounds check.
    localparam logic [3:0] NEIGH_DX [8] = '{4'd0, 4'd1, 4'd1, 4'd1, 4'd0, 4'hF, 4'hF, 4'hF};
    localparam logic [3:0] NEIGH_DY [8] = '{4'hF, 4'hF, 4'd0, 4'd1, 4'd1, 4'd1, 4'd0, 4'hF};

    // addr = y*15 + x, computed as (y<<4) - y + x in 8 bits.
    function automatic cell_addr_t cell_addr(input logic [3:0] x, input logic [3:0] y);
        return ({4'd0, y} << 4) - {4'd0, y} + {4'd0, x};
    endfunction

    // Row of a linear address (address / 15) without a divider.
    function automatic logic [3:0] addr_row(input cell_addr_t a);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 1; i < int'(GRID_H); i++) begin
            if (a >= cell_addr(4'd0, 4'(i))) r = 4'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/reveal_fifo.sv
// reveal_fifo: synchronous 256x8 FIFO of cell addresses pending reveal.
// Ports: clk_i/rst_i (async, active-high), push_i/din_i, pop_i, flush_i,
//        dout_o (registered, valid the cycle after pop_i), empty_o, full_o.
module reveal_fifo
    import minesweeper_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_i,
    input  cell_addr_t din_i,
    input  logic       pop_i,
    input  logic       flush_i,
    output cell_addr_t dout_o,
    output logic       empty_o,
    output logic       full_o
);

    cell_addr_t mem_q [256];
    logic [7:0] wr_ptr_q;
    logic [7:0] rd_ptr_q;
    logic [8:0] cnt_q;
    cell_addr_t dout_q;

    logic do_push;
    logic do_pop;

    assign empty_o = (cnt_q == 9'd0);
    assign full_o  = (cnt_q == 9'd256);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = dout_q;

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= din_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            dout_q   <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 8'd1;
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 8'd1;
                dout_q   <= mem_q[rd_ptr_q];
            end
            cnt_q <= cnt_q + {8'd0, do_push} - {8'd0, do_pop};
        end
    end

    // Each cell is enqueued at most once, so a push into a full FIFO is a design bug.
    a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full_o));

endmodule

// File: rtl/reveal_flood_ctrl.sv
// reveal_flood_ctrl: flood-fill reveal sequencer. On start it reads cell codes
// through a req/gnt board port, emits one reveal write per uncovered cell and
// cascades through zero-count regions via an address FIFO.
// Ports: clk_100MHz, sim_rst (async, active-high), restart, start/start_x/start_y,
//        flag_map, mem_req/mem_addr/mem_gnt/mem_rdata, reveal_we/reveal_addr,
//        busy, done, hit_mine, revealed_count, all_safe.
module reveal_flood_ctrl
    import minesweeper_pkg::*;
#(
    parameter int unsigned NUM_MINES = 40
) (
    input  logic         clk_100MHz,
    input  logic         sim_rst,
    input  logic         restart,
    input  logic         start,
    input  logic [3:0]   start_x,
    input  logic [3:0]   start_y,
    input  logic [224:0] flag_map,
    output logic         mem_req,
    output logic [7:0]   mem_addr,
    input  logic         mem_gnt,
    input  logic [3:0]   mem_rdata,
    output logic         reveal_we,
    output logic [7:0]   reveal_addr,
    output logic         busy,
    output logic         done,
    output logic         hit_mine,
    output logic [7:0]   revealed_count,
    output logic         all_safe
);

    reveal_state_t state_q, state_d;
    logic [2:0]    dir_q, dir_d;
    logic [3:0]    cur_x_q, cur_x_d;
    logic [3:0]    cur_y_q, cur_y_d;
    logic [224:0]  visited_q, visited_d;
    logic [7:0]    count_q, count_d;

    logic       fifo_push, fifo_pop, fifo_flush, fifo_empty, fifo_full;
    cell_addr_t fifo_din, fifo_dout;

    cell_addr_t start_addr, neigh_addr;
    logic [3:0] neigh_x, neigh_y, row_w, col_w;
    logic       start_ok, neigh_ok;

    reveal_fifo u_fifo (
        .clk_i   (clk_100MHz),
        .rst_i   (sim_rst),
        .push_i  (fifo_push),
        .din_i   (fifo_din),
        .pop_i   (fifo_pop),
        .flush_i (fifo_flush),
        .dout_o  (fifo_dout),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign start_addr = cell_addr(start_x, start_y);
    // Out-of-range start coordinates are treated like an unrevealable cell.
    assign start_ok   = (start_x < 4'(GRID_W)) && (start_y < 4'(GRID_H));

    // Popped address arrives in REQ; its x/y are latched there for NEIGH.
    assign row_w = addr_row(fifo_dout);
    assign col_w = 4'(fifo_dout - cell_addr(4'd0, row_w));

    assign neigh_x    = cur_x_q + NEIGH_DX[dir_q];
    assign neigh_y    = cur_y_q + NEIGH_DY[dir_q];
    assign neigh_addr = cell_addr(neigh_x, neigh_y);
    assign neigh_ok   = (neigh_x < 4'(GRID_W)) && (neigh_y < 4'(GRID_H)) &&
                        !visited_q[neigh_addr] && !flag_map[neigh_addr];

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        cur_x_d    = cur_x_q;
        cur_y_d    = cur_y_q;
        visited_d  = visited_q;
        count_d    = count_q;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;
        fifo_din   = start_addr;
        if (restart) begin
            state_d    = StIdle;
            fifo_flush = 1'b1;
            visited_d  = '0;
            count_d    = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (!start_ok || visited_q[start_addr] || flag_map[start_addr]) begin
                            state_d = StDone;
                        end else begin
                            visited_d[start_addr] = 1'b1;
                            fifo_push             = 1'b1;
                            state_d               = StPop;
                        end
                    end
                end
                StPop: begin
                    if (fifo_empty) begin
                        state_d = StDone;
                    end else begin
                        fifo_pop = 1'b1;
                        state_d  = StReq;
                    end
                end
                StReq: begin
                    cur_x_d = col_w;
                    cur_y_d = row_w;
                    if (mem_gnt) state_d = StRdata;
                end
                StRdata: begin
                    count_d = count_q + 8'd1;
                    if (mem_rdata == MINE_CODE) begin
                        fifo_flush = 1'b1;
                        state_d    = StDone;
                    end else if (mem_rdata == 4'd0) begin
                        dir_d   = 3'd0;
                        state_d = StNeigh;
                    end else begin
                        state_d = StPop;
                    end
                end
                StNeigh: begin
                    if (neigh_ok) begin
                        fifo_din              = neigh_addr;
                        fifo_push             = 1'b1;
                        visited_d[neigh_addr] = 1'b1;
                    end
                    dir_d = dir_q + 3'd1;
                    if (dir_q == 3'd7) state_d = StPop;
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_100MHz or posedge sim_rst) begin
        if (sim_rst) begin
            state_q   <= StIdle;
            dir_q     <= '0;
            cur_x_q   <= '0;
            cur_y_q   <= '0;
            visited_q <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            cur_x_q   <= cur_x_d;
            cur_y_q   <= cur_y_d;
            visited_q <= visited_d;
            count_q   <= count_d;
        end
    end

    // Outputs decode the state register; hit_mine must share the reveal cycle,
    // so it is qualified by the read data returned in RDATA.
    assign mem_req        = (state_q == StReq);
    assign mem_addr       = mem_req ? fifo_dout : 8'd0;
    assign reveal_we      = (state_q == StRdata);
    assign reveal_addr    = reveal_we ? fifo_dout : 8'd0;
    assign hit_mine       = reveal_we && (mem_rdata == MINE_CODE);
    assign done           = (state_q == StDone);
    assign busy           = (state_q != StIdle);
    assign revealed_count = count_q;
    assign all_safe       = (count_q == 8'(NUM_CELLS - NUM_MINES));

endmodule

// File: tb/tb_reveal_flood_ctrl.sv
// tb_reveal_flood_ctrl: directed bench for reveal_flood_ctrl with a BFS reference
// model feeding an expected-reveal queue that is checked on every reveal strobe.
module tb_reveal_flood_ctrl;

    logic         clk_100MHz = 1'b0;
    logic         sim_rst    = 1'b1;
    logic         restart    = 1'b0;
    logic         start      = 1'b0;
    logic [3:0]   start_x    = '0;
    logic [3:0]   start_y    = '0;
    logic [224:0] flag_map   = '0;
    logic         mem_req;
    logic [7:0]   mem_addr;
    logic         mem_gnt;
    logic [3:0]   mem_rdata  = '0;
    logic         reveal_we;
    logic [7:0]   reveal_addr;
    logic         busy, done, hit_mine, all_safe;
    logic [7:0]   revealed_count;

    always #5 clk_100MHz = ~clk_100MHz;

    reveal_flood_ctrl #(.NUM_MINES(40)) dut (
        .clk_100MHz     (clk_100MHz),
        .sim_rst        (sim_rst),
        .restart        (restart),
        .start          (start),
        .start_x        (start_x),
        .start_y        (start_y),
        .flag_map       (flag_map),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_gnt        (mem_gnt),
        .mem_rdata      (mem_rdata),
        .reveal_we      (reveal_we),
        .reveal_addr    (reveal_addr),
        .busy           (busy),
        .done           (done),
        .hit_mine       (hit_mine),
        .revealed_count (revealed_count),
        .all_safe       (all_safe)
    );

    typedef struct {
        int   addr;
        logic hit;
    } exp_t;

    exp_t       exp_q [$];
    exp_t       mon_e;
    int         n_assert  = 0;
    int         n_fail    = 0;
    int         done_cnt  = 0;
    int         stall_cfg = 0;
    int         stall_cnt = 0;
    int         mcount    = 0;
    logic [3:0] board [225];
    bit         mvis  [225];
    logic       prev_req  = 1'b0;
    logic [7:0] prev_addr = '0;
    int         DXS [8] = '{0, 1, 1, 1, 0, -1, -1, -1};
    int         DYS [8] = '{-1, -1, 0, 1, 1, 1, 0, -1};

    // Board memory: grant after stall_cfg refused cycles, data the cycle after grant.
    assign mem_gnt = mem_req && (stall_cnt >= stall_cfg);
    always @(posedge clk_100MHz) begin
        if (mem_req && !mem_gnt) stall_cnt <= stall_cnt + 1;
        else stall_cnt <= 0;
        if (mem_req && mem_gnt) mem_rdata <= board[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk_100MHz) begin
        if (reveal_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("reveal_extra", {24'd0, reveal_addr}, 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                chk("reveal_addr", {24'd0, reveal_addr}, mon_e.addr);
                chk("hit_mine", {31'd0, hit_mine}, {31'd0, mon_e.hit});
            end
        end else if (hit_mine === 1'b1) begin
            chk("hit_without_we", {31'd0, reveal_we}, 32'd1);
        end
        if (done === 1'b1) done_cnt++;
        if (mem_req && prev_req) chk("mem_addr_stable", {24'd0, mem_addr}, {24'd0, prev_addr});
        prev_req  = mem_req;
        prev_addr = mem_addr;
    end

    // Reference flood fill: BFS in N,NE,E,SE,S,SW,W,NW order, stop on a mine.
    task automatic model_start(input int x, input int y);
        int   q [$];
        int   a, c, cx, cy, nx, ny, n;
        exp_t e;
        a = y * 15 + x;
        if (mvis[a] || flag_map[a]) return;
        mvis[a] = 1'b1;
        q.push_back(a);
        while (q.size() > 0) begin
            c      = q.pop_front();
            e.addr = c;
            e.hit  = (board[c] == 4'd9);
            exp_q.push_back(e);
            mcount++;
            if (board[c] == 4'd9) begin
                q.delete();
            end else if (board[c] == 4'd0) begin
                cx = c % 15;
                cy = c / 15;
                for (int d = 0; d < 8; d++) begin
                    nx = cx + DXS[d];
                    ny = cy + DYS[d];
                    if (nx >= 0 && nx < 15 && ny >= 0 && ny < 15) begin
                        n = ny * 15 + nx;
                        if (!mvis[n] && !flag_map[n]) begin
                            mvis[n] = 1'b1;
                            q.push_back(n);
                        end
                    end
                end
            end
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        foreach (mvis[i]) mvis[i] = 1'b0;
        mcount = 0;
    endtask

    task automatic do_start(input int x, input int y);
        @(negedge clk_100MHz);
        start   = 1'b1;
        start_x = 4'(x);
        start_y = 4'(y);
        model_start(x, y);
        @(posedge clk_100MHz);
        #1 start = 1'b0;
    endtask

    task automatic do_restart();
        @(negedge clk_100MHz);
        restart = 1'b1;
        @(posedge clk_100MHz);
        #1 restart = 1'b0;
        clear_model();
    endtask

    // Returns the cycle number of done, counting the cycle after the start edge as 1.
    task automatic wait_done(output int cyc);
        cyc = 1;
        @(negedge clk_100MHz);
        while (done !== 1'b1 && cyc < 4000) begin
            @(posedge clk_100MHz);
            cyc++;
            @(negedge clk_100MHz);
        end
        chk("done_seen", {31'd0, done}, 32'd1);
    endtask

    task automatic check_end();
        chk("pending_reveals", exp_q.size(), 32'd0);
        chk("revealed_count", {24'd0, revealed_count}, mcount);
        chk("all_safe", {31'd0, all_safe}, {31'd0, (mcount == 185)});
    endtask

    initial begin
        int cyc, n, d0;
        foreach (board[i]) board[i] = 4'd1;

        // Reset values
        repeat (3) @(negedge clk_100MHz);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_reveal_we", {31'd0, reveal_we}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_hit_mine", {31'd0, hit_mine}, 32'd0);
        chk("rst_count", {24'd0, revealed_count}, 32'd0);
        chk("rst_all_safe", {31'd0, all_safe}, 32'd0);
        sim_rst = 1'b0;

        // Isolated non-zero cell (4,5) -> addr 79
        board[79] = 4'd3;
        do_start(4, 5);
        wait_done(cyc);
        chk("t1_done_cycle", cyc, 32'd5);
        @(posedge clk_100MHz);
        @(negedge clk_100MHz);
        chk("t1_busy_low", {31'd0, busy}, 32'd0);
        check_end();
        chk("t1_count", {24'd0, revealed_count}, 32'd1);

        // Zero corner cascade
        do_restart();
        board[0] = 4'd0;
        do_start(0, 0);
        wait_done(cyc);
        check_end();
        chk("t2_count", {24'd0, revealed_count}, 32'd4);

        // Mine at start cell (7,7) -> addr 112
        do_restart();
        board[112] = 4'd9;
        do_start(7, 7);
        wait_done(cyc);
        chk("t3_done_cycle", cyc, 32'd4);
        check_end();
        // Mine reached mid-cascade: pending cell 15 must be flushed, yet stays visited
        board[16] = 4'd9;
        do_start(0, 0);
        wait_done(cyc);
        check_end();
        do_start(0, 1);
        wait_done(cyc);
        chk("t3_visited_cycle", cyc, 32'd1);
        check_end();
        board[16]  = 4'd1;
        board[112] = 4'd1;

        // Grant stalls and flags
        do_restart();
        stall_cfg = 3;
        do_start(4, 5);
        wait_done(cyc);
        chk("t4_stall_done_cycle", cyc, 32'd8);
        check_end();
        board[32]    = 4'd0;
        flag_map[33] = 1'b1;
        do_start(2, 2);
        wait_done(cyc);
        check_end();
        do_start(3, 2);
        wait_done(cyc);
        chk("t4_flagged_cycle", cyc, 32'd1);
        check_end();
        do_start(2, 2);
        wait_done(cyc);
        chk("t4_visited_cycle", cyc, 32'd1);
        check_end();
        stall_cfg = 0;
        flag_map  = '0;

        // Restart during NEIGH on an all-zero board
        foreach (board[i]) board[i] = 4'd0;
        do_restart();
        do_start(7, 7);
        n = 0;
        while (reveal_we !== 1'b1 && n < 20) begin
            @(negedge clk_100MHz);
            n++;
        end
        chk("t5_reveal_seen", {31'd0, reveal_we}, 32'd1);
        @(posedge clk_100MHz);
        @(negedge clk_100MHz);
        restart = 1'b1;
        @(posedge clk_100MHz);
        #1 restart = 1'b0;
        clear_model();
        d0 = done_cnt;
        @(negedge clk_100MHz);
        chk("t5_busy_after_restart", {31'd0, busy}, 32'd0);
        chk("t5_count_cleared", {24'd0, revealed_count}, 32'd0);
        repeat (6) @(negedge clk_100MHz);
        chk("t5_no_done", done_cnt, d0);
        // restart and start together: start dropped
        restart = 1'b1;
        start   = 1'b1;
        start_x = 4'd0;
        start_y = 4'd0;
        @(posedge clk_100MHz);
        #1;
        restart = 1'b0;
        start   = 1'b0;
        @(negedge clk_100MHz);
        chk("t5_start_dropped", {31'd0, busy}, 32'd0);
        do_start(7, 7);
        wait_done(cyc);
        check_end();
        chk("t5_full_count", {24'd0, revealed_count}, 32'd225);

        // Win: 40 mines in addresses 185..224, busy start ignored
        foreach (board[i]) begin
            if (i >= 185) begin
                board[i] = 4'd9;
            end else begin
                n = 0;
                for (int d = 0; d < 8; d++) begin
                    int nx, ny;
                    nx = (i % 15) + DXS[d];
                    ny = (i / 15) + DYS[d];
                    if (nx >= 0 && nx < 15 && ny >= 0 && ny < 15 && (ny * 15 + nx) >= 185) n++;
                end
                board[i] = 4'(n);
            end
        end
        do_restart();
        chk("t6_all_safe_init", {31'd0, all_safe}, 32'd0);
        do_start(0, 0);
        @(negedge clk_100MHz);
        start   = 1'b1;
        start_x = 4'd5;
        start_y = 4'd13;
        @(posedge clk_100MHz);
        #1 start = 1'b0;
        wait_done(cyc);
        check_end();
        for (int a = 0; a < 185; a++) begin
            if (!mvis[a]) begin
                do_start(a % 15, a / 15);
                wait_done(cyc);
                check_end();
            end
        end
        chk("t6_count", {24'd0, revealed_count}, 32'd185);
        chk("t6_all_safe", {31'd0, all_safe}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
